// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin sharing of one prescaled one-shot timebase among requesters
module timer_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int PRESCALE = 24999,
    parameter int PS_W     = 15,
    parameter int DUR_W    = 8
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*DUR_W-1:0] dur,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   idx, ptr, sel, cand;
    logic [DUR_W-1:0]   remaining;
    logic [PS_W-1:0]    prescaler;
    logic               tick;

    assign tick = prescaler == PS_W'(PRESCALE);

    // round-robin pick: first set request after ptr, wrapping
    always_comb begin
        sel  = ptr;
        cand = ptr;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (req[cand]) sel = cand;
        end
    end

    // state register
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // next state and outputs; a zero duration still shows one grant cycle
    always_comb begin
        state_next = state;
        grant      = '0;
        done       = '0;
        busy       = 1'b0;
        case (state)
            IDLE: state_next = |req ? RUN : IDLE;
            RUN: begin
                grant      = NUM_REQ'(1) << idx;
                busy       = 1'b1;
                state_next = !req[idx] ? IDLE :
                             (remaining == '0 || (tick && remaining == DUR_W'(1))) ? DONE : RUN;
            end
            DONE: begin
                done       = NUM_REQ'(1) << idx;
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // owner latch, prescaler, tick countdown and round-robin pointer
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            idx       <= '0;
            ptr       <= IDX_W'(NUM_REQ - 1);
            remaining <= '0;
            prescaler <= '0;
        end else begin
            case (state)
                IDLE: begin
                    prescaler <= '0;
                    if (|req) begin
                        idx       <= sel;
                        remaining <= dur[sel*DUR_W +: DUR_W];
                    end
                end
                RUN: begin
                    if (!req[idx]) begin
                        ptr       <= idx;
                        prescaler <= '0;
                        remaining <= '0;
                    end else if (tick) begin
                        prescaler <= '0;
                        if (remaining != '0) remaining <= remaining - DUR_W'(1);
                    end else begin
                        prescaler <= prescaler + PS_W'(1);
                    end
                end
                DONE: begin
                    ptr       <= idx;
                    prescaler <= '0;
                    remaining <= '0;
                end
                default: begin
                    prescaler <= '0;
                    remaining <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed checks of grant order, expiry timing, abort and reset
module tb_timer_arbiter;
    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] dur = '0;
    logic [3:0]  grant, done;
    logic        busy;
    int          total = 0;
    int          bad = 0;
    int          n;

    timer_arbiter #(.NUM_REQ(4), .PRESCALE(3), .PS_W(2), .DUR_W(8)) dut (
        .clk_in(clk_in), .rst(rst), .req(req), .dur(dur),
        .grant(grant), .done(done), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // counts cycles from the current (granted) cycle until done[i] is seen
    task automatic wait_done(input int i, output int cnt);
        cnt = 0;
        while (done[i] !== 1'b1 && cnt < 2000) begin
            step();
            cnt++;
        end
    endtask

    task automatic wait_grant(output int cnt);
        cnt = 0;
        while (grant === 4'b0 && cnt < 50) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        #12;
        chk("reset_grant", {28'b0, grant}, 0);
        chk("reset_done", {28'b0, done}, 0);
        chk("reset_busy", {31'b0, busy}, 0);
        rst = 1'b1;
        step();

        // single request, 5 ticks of 4 cycles
        dur[7:0] = 8'd5;
        req = 4'b0001;
        step();
        chk("t1_grant", {28'b0, grant}, 4'b0001);
        chk("t1_busy", {31'b0, busy}, 1);
        wait_done(0, n);
        chk("t1_latency", n, 20);
        chk("t1_done", {28'b0, done}, 4'b0001);
        chk("t1_grant_at_done", {28'b0, grant}, 0);
        req = 4'b0000;
        step();
        chk("t1_done_pulse", {28'b0, done}, 0);
        step();
        chk("t1_busy_low", {31'b0, busy}, 0);

        // fresh pointer, all requesters share round-robin
        rst = 1'b0;
        step();
        rst = 1'b1;
        dur = {8'd1, 8'd1, 8'd1, 8'd1};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(n);
            chk("t2_grant", {28'b0, grant}, 32'(1 << (k % 4)));
            wait_done(k % 4, n);
            chk("t2_latency", n, 4);
            chk("t2_done", {28'b0, done}, 32'(1 << (k % 4)));
        end
        req = 4'b0000;
        step();
        step();

        // zero duration: one grant cycle then done
        dur[23:16] = 8'd0;
        req = 4'b0100;
        step();
        chk("t3_grant", {28'b0, grant}, 4'b0100);
        step();
        chk("t3_done", {28'b0, done}, 4'b0100);
        chk("t3_grant_off", {28'b0, grant}, 0);
        req = 4'b0000;
        step();
        step();

        // abort after 7 granted cycles, then wrap past 2,3 to requester 0
        dur[15:8] = 8'd10;
        req = 4'b0010;
        step();
        chk("t4_grant", {28'b0, grant}, 4'b0010);
        repeat (6) step();
        req = 4'b0000;
        step();
        chk("t4_abort_grant", {28'b0, grant}, 0);
        chk("t4_abort_done", {28'b0, done}, 0);
        chk("t4_abort_busy", {31'b0, busy}, 0);
        req = 4'b0011;
        step();
        chk("t4_rr_wrap", {28'b0, grant}, 4'b0001);
        req = 4'b0000;
        step();
        step();

        // duration changes after latch are ignored
        dur[7:0] = 8'd5;
        req = 4'b0001;
        step();
        chk("t6_grant", {28'b0, grant}, 4'b0001);
        dur[7:0] = 8'd2;
        wait_done(0, n);
        chk("t6_latency", n, 20);
        req = 4'b0000;
        step();
        step();

        // async reset mid-run, then a full 255-tick count
        dur[7:0] = 8'd255;
        req = 4'b0001;
        step();
        chk("t5_grant", {28'b0, grant}, 4'b0001);
        repeat (10) step();
        rst = 1'b0;
        #1;
        chk("t5_rst_grant", {28'b0, grant}, 0);
        chk("t5_rst_busy", {31'b0, busy}, 0);
        chk("t5_rst_done", {28'b0, done}, 0);
        step();
        rst = 1'b1;
        step();
        chk("t5_regrant", {28'b0, grant}, 4'b0001);
        wait_done(0, n);
        chk("t5_latency", n, 1020);
        chk("t5_done", {28'b0, done}, 4'b0001);
        req = 4'b0000;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
